// File: rtl/transmitter.sv
// UART transmit side: valid/ready byte intake with a one-deep holding register,
// serialised as start bit, eight data bits MSB first, then one or two stop bits.
module transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] DataIN,
    input  logic       Send,
    output logic       Ready,
    output logic       tx,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [7:0]  shift_data;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic        stop_cnt;

    logic        accept;
    logic        bit_done;
    logic        frame_end;
    logic        reload;
    logic        bypass;
    logic [7:0]  load_byte;

    assign Ready     = !hold_full;
    assign accept    = Send && Ready;
    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == STOP) && bit_done && (stop_cnt == STOP_LAST);
    // A new frame may start from IDLE or straight out of the last stop cycle;
    // a queued byte takes priority, otherwise a fresh accept skips the holding register.
    assign reload    = ((state == IDLE) || frame_end) && hold_full;
    assign bypass    = ((state == IDLE) || frame_end) && !hold_full && accept;
    assign load_byte = reload ? hold_data : DataIN;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else if (accept && !bypass) begin
            hold_data <= DataIN;
            hold_full <= 1'b1;
        end else if (reload) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            shift_data <= 8'h00;
            bit_idx    <= 3'd0;
            baud_cnt   <= 16'd0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            Busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reload || bypass) begin
                        shift_data <= load_byte;
                        baud_cnt   <= 16'd0;
                        state      <= START;
                        tx         <= 1'b0;
                        Busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd7;
                        state    <= DATA;
                        tx       <= shift_data[7];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd0) begin
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                            tx      <= shift_data[bit_idx - 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= 16'd0;
                        if (stop_cnt == STOP_LAST) begin
                            if (reload || bypass) begin
                                shift_data <= load_byte;
                                state      <= START;
                                tx         <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                Busy  <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/transmitter.md
# transmitter

Serial transmit side of the UART link: accepts parallel bytes over a valid/ready handshake and serialises each as a frame on `tx`. A frame is one start bit (0), eight data bits MSB first, then stop bit(s) (1). With default parameters the frame is bit-exact with the team's receiver, which samples one bit per clock. A one-deep holding register lets the next byte be accepted during a frame, so frames go out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..65535.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `CLK`  in  1: sole clock; all logic on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `DataIN`  in  8: byte to transmit; sampled only on an accept cycle.
- `Send`  in  1: request (valid); may be held high across cycles.
- `Ready`  out  1: high when a byte can be accepted this cycle (holding register empty).
- `tx`  out  1: serial line, idle high; registered output.
- `Busy`  out  1: high from the first start-bit cycle through the last stop-bit cycle of the final queued frame.

## Operation
- **Accept:**
  - An accept occurs on a rising edge where `Send && Ready`.
  - `DataIN` is captured into the holding register, which becomes full.
- **FSM states:**
  - **IDLE**
    - `tx`=1, `Busy`=0.
    - If the holding register is full, or an accept occurs this edge, load the shift register, empty the holding register, and go to START.
    - An accept direct from IDLE bypasses the holding register, so `Ready` stays 1.
  - **START**
    - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 7.
  - **DATA**
    - `tx`=shift[index] for `CLKS_PER_BIT` cycles per bit; index counts 7 down to 0.
    - After bit 0, go to STOP.
  - **STOP**
    - `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
    - On the last STOP cycle: if the holding register is full, or an accept occurs on that same edge, reload and go to START, with no idle cycle between frames.
    - Otherwise go to IDLE.
- **Counters:**
  - Baud counter is 16 bits and counts 0..`CLKS_PER_BIT`-1, with wrap-around to 0 at the end of each bit.
  - Stop-bit counter is 1 bit.
- **`Ready`** = NOT holding-register-full. One byte can therefore be queued while a frame is in progress; a second `Send` stalls until the queued byte moves into the shift register.
- **Simultaneous reload and accept:** when the holding register empties into the shift register on the same edge as an accept, the new byte is captured into the holding register. No byte is lost or duplicated.
- **Stable data:** `DataIN` changes after an accept do not affect the frame in flight.
- **Reset asserted at any time, including mid-frame:**
  - Outputs go immediately to `tx`=1, `Ready`=1, `Busy`=0; state is IDLE.
  - Holding and shift registers are cleared and counters are zeroed.
  - The partial frame is abandoned; there is no stop-bit completion.

## Timing
- **Reset values:** `tx`=1, `Ready`=1, `Busy`=0.
- **Start latency:** an accept from IDLE at edge N drives `tx`=0 and `Busy`=1 from edge N. The start bit is visible in the cycle after edge N.
- **Frame length:** (9+`STOP_BITS`)*`CLKS_PER_BIT` cycles. With defaults this is 10 cycles: start, bits 7..0, stop.
- **Back-to-back:** the next start bit begins on the edge ending the previous last stop cycle. Frame period equals frame length exactly.
- **`Ready` timing:**
  - Falls on the edge that fills the holding register.
  - Rises on the edge that moves the held byte into the shift register.
- **`Busy` timing:** falls on the edge that enters IDLE with nothing queued.

## Test plan
- **Reset, then single byte (defaults):** hold `Reset` low, release, send 0xA5 at edge N. Required: `tx` over cycles N..N+9 = 0,1,0,1,0,0,1,0,1,1. `Busy` is high over exactly those 10 cycles, then `tx`=1 and `Busy`=0.
- **Back-to-back (defaults):** `Send` held high with 0x3C, then 0xFF. Required: 20 contiguous cycles 0,00111100,1,0,11111111,1. `Ready` drops after the second accept and rises at the second start bit.
- **Baud divide:** `CLKS_PER_BIT`=4, `STOP_BITS`=2, send 0x81. Required: each bit is held 4 cycles, the frame is 44 cycles long, and `tx`=1 during the 8 stop cycles.
- **Holding-register stall:** with a frame in flight and the holding register full, present 0x55 with `Send` high. Required: `Ready`=0 and no accept until the reload edge; 0x55 is then queued and transmitted third, with no loss or duplicate.
- **Reset mid-frame:** assert `Reset` during DATA bit 4 of 0x00. Required: `tx`=1, `Ready`=1, `Busy`=0 immediately, before the next clock edge. A byte 0x12 sent after release produces a clean, complete frame.
- **Loopback:** connect `tx` to the receiver's `rx`, defaults, send 0x00, 0xFF, 0xA5. Required: the receiver's `DataOUT` shows each byte in order.
